// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared widths, FSM states and request record for apb_master_arb.
// Widths default to 32-bit address/data when the shared defines are absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_WIDTH
`define STRB_WIDTH 4
`endif

package apb_arb_pkg;
    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;
    localparam int STRB_W = `STRB_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } apb_req_t;
endpackage

// File: rtl/apb_master_arb_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);
    // Scan from the farthest offset down so the nearest requester overwrites the rest
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (en_i && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
                idx_o = ID_W'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin APB4 master sharing one slave port between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [STRB_W-1:0]         PSTRB,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    apb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    apb_req_t           req_q, req_d, sel_req;
    logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               done, abort;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Reads carry zero data and strobes so the bus shows nothing stale
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_req.write = req_write[i];
                sel_req.addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_req.wdata = req_write[i] ? req_wdata[i*DATA_W +: DATA_W] : '0;
                sel_req.strb  = req_write[i] ? req_strb[i*STRB_W +: STRB_W] : '0;
            end
        end
    end

    assign done = (state_q == ACCESS) && PREADY;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Abort on the stalled cycle that brings the count to the limit; PREADY=1 wins
    assign cnt_d = (state_q == SETUP) ? '0 :
                   (state_q == ACCESS && !PREADY) ? cnt_q + 1'b1 : cnt_q;
    assign abort = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        req_d       = req_q;
        id_d        = id_q;
        rsp_valid_d = done || abort;
        rsp_id_d    = (done || abort) ? id_q : rsp_id_q;
        rsp_rdata_d = done ? (req_q.write ? '0 : PRDATA) : abort ? '0 : rsp_rdata_q;
        rsp_err_d   = done ? PSLVERR : abort ? 1'b1 : rsp_err_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d  = SETUP;
                    req_d    = sel_req;
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (done || abort) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            req_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            req_q       <= req_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The grant is combinational, so keep it quiet while reset is held
    assign req_ready = gnt & {NUM_REQ{PRESETn}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = state_q != IDLE;
    assign PENABLE   = state_q == ACCESS;
    assign PWRITE    = req_q.write;
    assign PADDR     = req_q.addr;
    assign PWDATA    = req_q.wdata;
    assign PSTRB     = req_q.strb;
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Round-robin APB4 master that shares one APB slave port between `NUM_REQ` local requesters. It accepts one request at a time, sequences the IDLE/SETUP/ACCESS protocol on the `PSEL/PENABLE/PADDR/PWDATA/PSTRB/PWRITE` bus and waits for `PREADY`. It then returns `PRDATA/PSLVERR` to the originating requester, tagged with its index. It sits between the subsystem's register clients and the APB slave under test, and drives the same signal set the bench interface samples.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `ID_W`, `$clog2(NUM_REQ)`, requester index width.
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles before abort. Only used with `APB_ARB_TIMEOUT_EN`.
- Address, data and strobe widths come from the shared `ADDR_WIDTH`, `DATA_WIDTH` and `STRB_WIDTH` defines.

Ports:
- `PCLK` in 1: single clock, all logic on the rising edge.
- `PRESETn` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_ready` out NUM_REQ: one-hot grant/accept pulse.
- `req_write` in NUM_REQ: 1 = write.
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened addresses, requester i at slice i.
- `req_wdata` in NUM_REQ*DATA_WIDTH: flattened write data.
- `req_strb` in NUM_REQ*STRB_WIDTH: flattened write strobes.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_id` out ID_W: index of the completed requester.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes.
- `rsp_err` out 1: PSLVERR or timeout.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB master controls.
- `PADDR` out ADDR_WIDTH: APB address.
- `PWDATA` out DATA_WIDTH: APB write data.
- `PSTRB` out STRB_WIDTH: APB write strobes.
- `PRDATA` in DATA_WIDTH: APB read data.
- `PREADY` in 1: APB ready.
- `PSLVERR` in 1: APB slave error.

## Operation
- FSM states are IDLE, SETUP and ACCESS.
- **IDLE:**
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready[g]` combinationally in that cycle and register the granted request's fields, `rsp_id` and `g`.
  - Advance to SETUP.
  - Set `rr_ptr` to `(g+1) % NUM_REQ`.
- **SETUP:** `PSEL=1`, `PENABLE=0`, APB address/data/control driven from the captured registers. Next state is always ACCESS.
- **ACCESS:**
  - `PSEL=1`, `PENABLE=1`, and all other APB outputs held stable.
  - If `PREADY=1`, the transfer completes: capture `PRDATA` (reads only) and `PSLVERR`, then return to IDLE.
- **Reads:** `PSTRB` is driven to all zeros. `PWDATA` is don't-care and is driven 0.
- **Response:** `rsp_valid` pulses in the cycle after completion with `rsp_id`, `rsp_rdata` and `rsp_err` valid. These three hold their values until the next completion.
- **Requester rules:** a requester must hold `req_valid` and its fields stable until `req_ready`. Dropping `req_valid` before grant is legal and simply loses arbitration.
- **Simultaneous events:** completion and a new `req_valid` in the same cycle give no grant that cycle; the grant happens in the following IDLE cycle.
- **Reset:** asserting `PRESETn` mid-transfer aborts immediately. The bus returns to idle and no `rsp_valid` is issued for the aborted transfer.

## Timing
- **Reset values:** FSM=IDLE, `rr_ptr=0`, all APB outputs 0, `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_rdata=0`, `rsp_err=0`.
- **Zero-wait-state transfer:**
  - grant at cycle T;
  - SETUP at T+1;
  - ACCESS at T+2 with `PREADY=1`;
  - `rsp_valid` at T+3;
  - next grant no earlier than T+3.
- **Wait states:** each cycle of `PREADY=0` in ACCESS adds one cycle.
- **Throughput:** maximum one transfer per 3 cycles.
- `PSEL` is never deasserted between SETUP and completion.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter of ID width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments each ACCESS cycle with `PREADY=0`.
  - When it reaches `TIMEOUT_CYCLES`, the transfer is abandoned: return to IDLE, `rsp_valid` next cycle with `rsp_err=1` and `rsp_rdata=0`.
  - A `PREADY=1` in the same cycle the count reaches the limit wins; the transfer completes normally.
- `APB_ARB_TIMEOUT_EN` undefined: no counter is built, and ACCESS waits indefinitely for `PREADY`.

## Structure
- Shared package `apb_arb_pkg`:
  - FSM enum `apb_state_e` (IDLE/SETUP/ACCESS);
  - request struct typedef holding write, addr, wdata and strb.
- One sub-module, `rr_arbiter`: parameterised NUM_REQ round-robin picker. Inputs: request vector, pointer, enable. Outputs: one-hot grant and encoded index.
- The FSM, capture registers and timeout counter live in `apb_master_arb`.

## Test plan
1. Single write from req 2, `addr=0x10`, `wdata=0xDEADBEEF`, `strb=0xF`, `PREADY` tied 1 → SETUP at T+1, ACCESS at T+2, `rsp_valid` at T+3 with `rsp_id=2`, `rsp_err=0`.
2. Read from req 0 at `addr=0x10` with `PRDATA=0xDEADBEEF` and 3 wait states → `PSTRB=0`, ACCESS lasts 4 cycles, `rsp_rdata=0xDEADBEEF`.
3. All 4 requesters hold `req_valid` continuously → grant order 0,1,2,3,0, one transfer every 3 cycles.
4. Slave returns `PSLVERR=1` on a write from req 1 → `rsp_err=1`, `rsp_rdata=0`, `rsp_id=1`.
5. With `APB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, `PREADY` stuck 0 → after 16 ACCESS cycles, IDLE and `rsp_valid` with `rsp_err=1`. Without the macro, `PSEL` stays high.
6. `PRESETn` asserted during ACCESS → all outputs 0 immediately, no `rsp_valid`; after release, the next grant starts from requester 0.
